// File: rtl/serial_sub_if.sv
// Handshake/data bundle for the bit-serial subtractor.
// The requester drives start/operands; the subtractor returns status and result.
interface serial_sub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (output start, a, b, bin, input busy, done, diff, bout);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout);
endinterface

// File: rtl/serial_sub.sv
// Bit-serial subtractor: one full-subtractor cell reused over WIDTH cycles,
// LSB first, with a registered borrow. diff/bout only update on the done edge.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  serial_sub_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sa, sb;
  logic [WIDTH-2:0] acc;      // partial difference bits, filled from the MSB end
  logic             br;
  logic [CW-1:0]    cnt;
  logic             busy_q, done_q, bout_q;
  logic [WIDTH-1:0] diff_q;

  logic             d, br_next;
  logic [WIDTH-1:0] nxt;

  // Full-subtractor cell on the current LSBs, plus the shifted partial result.
  always_comb begin
    d       = sa[0] ^ sb[0] ^ br;
    br_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    nxt     = {d, acc};
  end

  // Control FSM with operand, borrow and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sa     <= '0;
      sb     <= '0;
      acc    <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            sa     <= bus.a;
            sb     <= bus.b;
            br     <= bus.bin;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= SHIFT;
          end else begin
            state  <= IDLE;
          end
        end
        SHIFT: begin
          acc <= nxt[WIDTH-1:1];
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          br  <= br_next;
          cnt <= cnt + 1'b1;
          // Last bit: the full result is {d, acc}; publish it with the borrow.
          if (cnt == CW'(WIDTH - 1)) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            diff_q <= nxt;
            bout_q <= br_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
endmodule

// File: tb/tb_serial_sub.sv
// Bench for serial_sub: table vectors, hand-written corner sequences and
// random regression at WIDTH=8 and WIDTH=2, checked through result scoreboards.
module tb_serial_sub;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_sub_if #(.WIDTH(8)) if8();
  serial_sub_if #(.WIDTH(2)) if2();

  serial_sub #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  serial_sub #(.WIDTH(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bo;
  } vec_t;

  logic [8:0] q8[$];   // {bout, diff} expected from the 8-bit unit
  logic [2:0] q2[$];   // {bout, diff} expected from the 2-bit unit
  logic [8:0] e8;
  logic [2:0] e2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] model8(input logic [7:0] a, input logic [7:0] b, input logic bin);
    return {1'b0, a} - {1'b0, b} - {8'd0, bin};
  endfunction

  function automatic logic [2:0] model2(input logic [1:0] a, input logic [1:0] b, input logic bin);
    return {1'b0, a} - {1'b0, b} - {2'd0, bin};
  endfunction

  // Scoreboard side: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n && if8.done) begin
      if (q8.size() == 0) begin
        checks++; errors++;
        $display("FAIL done8_unexpected got done=1 want no done");
      end else begin
        e8 = q8.pop_front();
        chk("result8", {23'd0, if8.bout, if8.diff}, {23'd0, e8});
      end
    end
    if (rst_n && if2.done) begin
      if (q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL done2_unexpected got done=1 want no done");
      end else begin
        e2 = q2.pop_front();
        chk("result2", {29'd0, if2.bout, if2.diff}, {29'd0, e2});
      end
    end
  end

  // Waits for done on the 8-bit unit; returns negedges elapsed.
  task automatic wait_done8(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!if8.done && cyc < 40);
    if (!if8.done) begin
      checks++; errors++;
      $display("FAIL done8_timeout got no done want done within 40 cycles");
    end
  endtask

  // One full operation on the 8-bit unit with busy/done timing checked.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin, input string name);
    bit bad;
    @(posedge clk); #1;
    if8.start = 1'b1; if8.a = a; if8.b = b; if8.bin = bin;
    q8.push_back(model8(a, b, bin));
    @(posedge clk); #1;
    if8.start = 1'b0;
    if8.a = 8'($urandom); if8.b = 8'($urandom); if8.bin = 1'($urandom);
    bad = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (i < 9) bad |= !(if8.busy && !if8.done);
      else       bad |= !(if8.done && !if8.busy);
    end
    chk({name, "_latency"}, {31'd0, bad}, 32'd0);
  endtask

  vec_t vecs[6];
  vec_t pairs[4];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    logic [1:0] ra, rb;
    logic       rbin;

    if8.start = 0; if8.a = 0; if8.b = 0; if8.bin = 0;
    if2.start = 0; if2.a = 0; if2.b = 0; if2.bin = 0;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[4] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0};
    vecs[5] = '{8'h33, 8'h44, 1'b0, 8'hEF, 1'b1};

    pairs[0] = '{8'h33, 8'h44, 1'b0, 8'hEF, 1'b1};
    pairs[1] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0};
    pairs[2] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0};
    pairs[3] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset8", {28'd0, if8.busy, if8.done, if8.bout, |if8.diff}, 32'd0);
    chk("reset2", {28'd0, if2.busy, if2.done, if2.bout, |if2.diff}, 32'd0);
    rst_n = 1'b1;

    // Table vectors: expected values are the hand-derived constants
    for (int i = 0; i < 6; i++) begin
      q8.push_back({vecs[i].bo, vecs[i].d});
      @(posedge clk); #1;
      if8.start = 1'b1; if8.a = vecs[i].a; if8.b = vecs[i].b; if8.bin = vecs[i].bin;
      @(posedge clk); #1;
      if8.start = 1'b0;
      wait_done8(cyc);
      chk("table_latency", cyc, 9);
      chk("table_diff", {24'd0, if8.diff}, {24'd0, vecs[i].d});
    end

    // Random regression, WIDTH=8
    for (int i = 0; i < 1000; i++)
      op8(8'($urandom), 8'($urandom), 1'($urandom), "rand8");

    // Start during SHIFT is ignored
    @(posedge clk); #1;
    if8.start = 1'b1; if8.a = 8'h10; if8.b = 8'h01; if8.bin = 1'b0;
    q8.push_back(9'h00F);
    @(posedge clk); #1;
    if8.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    if8.start = 1'b1; if8.a = 8'hAA; if8.b = 8'h55;
    @(posedge clk); #1;
    if8.start = 1'b0;
    chk("ignored_busy", {31'd0, if8.busy}, 32'd1);
    wait_done8(cyc);
    chk("ignored_latency", cyc, 5);
    repeat (15) @(negedge clk);
    chk("ignored_single_done", q8.size(), 0);

    // Back-to-back with start held high
    @(posedge clk); #1;
    if8.start = 1'b1; if8.a = pairs[0].a; if8.b = pairs[0].b; if8.bin = pairs[0].bin;
    q8.push_back({pairs[0].bo, pairs[0].d});
    @(posedge clk); #1;
    for (int j = 1; j < 4; j++) begin
      wait_done8(cyc);
      chk("b2b_spacing", cyc, 9);
      if8.a = pairs[j].a; if8.b = pairs[j].b; if8.bin = pairs[j].bin;
      q8.push_back({pairs[j].bo, pairs[j].d});
      @(posedge clk); #1;
    end
    if8.start = 1'b0;
    wait_done8(cyc);
    chk("b2b_spacing_last", cyc, 9);

    // Async reset in the middle of SHIFT
    @(posedge clk); #1;
    if8.start = 1'b1; if8.a = 8'h5A; if8.b = 8'h3C; if8.bin = 1'b0;
    @(posedge clk); #1;
    if8.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_reset_busy", {31'd0, if8.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", {23'd0, if8.busy, if8.done, if8.bout, if8.diff}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("abort_idle_busy", {31'd0, if8.busy}, 32'd0);
    op8(8'h09, 8'h03, 1'b1, "post_reset");
    chk("post_reset_diff", {23'd0, if8.bout, if8.diff}, 32'h005);

    // Random regression, WIDTH=2
    for (int i = 0; i < 1000; i++) begin
      ra = 2'($urandom); rb = 2'($urandom); rbin = 1'($urandom);
      @(posedge clk); #1;
      if2.start = 1'b1; if2.a = ra; if2.b = rb; if2.bin = rbin;
      q2.push_back(model2(ra, rb, rbin));
      @(posedge clk); #1;
      if2.start = 1'b0;
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!if2.done && cyc < 10);
      if (i < 3) chk("w2_latency", cyc, 3);
      if (!if2.done) begin
        checks++; errors++;
        $display("FAIL done2_timeout got no done want done within 10 cycles");
      end
    end

    repeat (4) @(negedge clk);
    chk("q8_drained", q8.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
